// File: rtl/norm_shift_unit.sv
// norm_shift_unit: leading-zero count then left normalize, 2-stage valid/ready pipe.
// NORM_CARRY_EN adds Carry_i/Right_o: a 1-bit right shift for adder carry-out.
module norm_shift_unit #(
  parameter int EWR = 5,
  parameter int SWR = 26
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  output logic           ready_o,
  input  logic [SWR-1:0] Data_i,
`ifdef NORM_CARRY_EN
  input  logic           Carry_i,
  output logic           Right_o,
`endif
  output logic           valid_o,
  input  logic           ready_i,
  output logic [SWR-1:0] Data_o,
  output logic [EWR-1:0] Shift_Value_o,
  output logic           Zero_o
);

  if (SWR > 2**EWR - 1) begin : g_bad_cfg
    $error("norm_shift_unit: SWR must be <= 2**EWR-1");
  end

  typedef struct packed {
    logic [SWR-1:0] data;
    logic [EWR-1:0] lz;
  } s1_t;

  s1_t            s1;
  logic           s1_v;
  logic           s2_v;
  logic           s1_adv;
  logic           s2_adv;
  logic [EWR-1:0] lz;
`ifdef NORM_CARRY_EN
  logic           s1_cy;
`endif

  // highest set bit wins, so scan upward and let later hits override
  always_comb begin
    lz = EWR'(SWR);
    for (int i = 0; i < SWR; i++)
      if (Data_i[i]) lz = EWR'(SWR - 1 - i);
  end

  assign s2_adv  = ~s2_v | ready_i;
  assign s1_adv  = ~s1_v | s2_adv;
  assign ready_o = rst & s1_adv;
  assign valid_o = s2_v;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v          <= 1'b0;
      s2_v          <= 1'b0;
      s1            <= '0;
      Data_o        <= '0;
      Shift_Value_o <= '0;
      Zero_o        <= 1'b0;
`ifdef NORM_CARRY_EN
      s1_cy         <= 1'b0;
      Right_o       <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s1_v <= load_i;
        if (load_i) begin
          s1.data <= Data_i;
          s1.lz   <= lz;
`ifdef NORM_CARRY_EN
          s1_cy   <= Carry_i;
`endif
        end
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) begin
`ifdef NORM_CARRY_EN
          if (s1_cy) begin
            Data_o        <= {1'b1, s1.data[SWR-1:1]};
            Shift_Value_o <= EWR'(1);
            Zero_o        <= 1'b0;
            Right_o       <= 1'b1;
          end else begin
            Data_o        <= s1.data << s1.lz;
            Shift_Value_o <= s1.lz;
            Zero_o        <= (s1.lz == EWR'(SWR));
            Right_o       <= 1'b0;
          end
`else
          Data_o        <= s1.data << s1.lz;
          Shift_Value_o <= s1.lz;
          Zero_o        <= (s1.lz == EWR'(SWR));
`endif
        end
      end
    end
  end

endmodule
